// File: rtl/bus_register_file.sv
// Register file of DEPTH x WIDTH registers with in-place INC/DEC/SHL/SHR/CLR and zero/carry flags.
// Optional macro OUT_REG_EN registers the tri-state read path (1-cycle read latency).
module bus_register_file #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_in,
  input  logic              enable_out,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  data,
  output logic [WIDTH-1:0]  out,
  output logic              zero,
  output logic              carry
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_LOAD = 3'd1,
    OP_INC  = 3'd2,
    OP_DEC  = 3'd3,
    OP_SHL  = 3'd4,
    OP_SHR  = 3'd5,
    OP_CLR  = 3'd6,
    OP_RSVD = 3'd7
  } op_t;

  logic [WIDTH-1:0] regs [DEPTH];
  logic             wr_ok, rd_ok, exec, do_wr, nc;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [WIDTH-1:0] cur, res;

  assign wr_ok  = {1'b0, wr_addr} < DEPTH_A;
  assign rd_ok  = {1'b0, rd_addr} < DEPTH_A;
  assign wr_idx = IDX_W'(wr_addr);
  assign rd_idx = IDX_W'(rd_addr);
  assign cur    = wr_ok ? regs[wr_idx] : '0;

  always_comb begin
    exec = 1'b1;
    res  = cur;
    nc   = 1'b0;
    case (op_t'(op))
      OP_LOAD: res = data;
      OP_INC: begin
        res = cur + WIDTH'(1);
        nc  = &cur;
      end
      OP_DEC: begin
        res = cur - WIDTH'(1);
        nc  = ~|cur;
      end
      OP_SHL: begin
        res = {cur[WIDTH-2:0], 1'b0};
        nc  = cur[WIDTH-1];
      end
      OP_SHR: begin
        res = {1'b0, cur[WIDTH-1:1]};
        nc  = cur[0];
      end
      OP_CLR:  res = '0;
      default: exec = 1'b0;  // HOLD and reserved leave register and flags alone
    endcase
  end

  assign do_wr = enable_in & wr_ok & exec;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      zero  <= 1'b0;
      carry <= 1'b0;
    end else if (do_wr) begin
      regs[wr_idx] <= res;
      zero         <= (res == '0);
      carry        <= nc;
    end
  end

`ifdef OUT_REG_EN
  logic [WIDTH-1:0] rd_next, out_q;
  logic             oe_q;

  // Capture the post-edge contents, so a same-edge write to rd_addr is seen.
  always_comb begin
    rd_next = '0;
    if (rd_ok) rd_next = (do_wr && (wr_idx == rd_idx)) ? res : regs[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q <= '0;
      oe_q  <= 1'b0;
    end else begin
      out_q <= rd_next;
      oe_q  <= enable_out;
    end
  end

  assign out = oe_q ? out_q : 'z;
`else
  logic [WIDTH-1:0] rd_val;

  assign rd_val = rd_ok ? regs[rd_idx] : '0;
  assign out    = enable_out ? rd_val : 'z;
`endif

endmodule

// File: tb/tb_bus_register_file.sv
// Randomized + directed scoreboard bench for bus_register_file (WIDTH=8, DEPTH=4, ADDR_W=3 so
// addresses 4..7 exercise the out-of-range path).
module tb_bus_register_file;

  localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, INC = 3'd2, DEC = 3'd3,
                         SHL = 3'd4, SHR = 3'd5, CLR = 3'd6, RSV = 3'd7;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable_in = 1'b0;
  logic       enable_out = 1'b0;
  logic [2:0] op = 3'd0;
  logic [2:0] wr_addr = 3'd0;
  logic [2:0] rd_addr = 3'd0;
  logic [7:0] data = 8'd0;
  wire  [7:0] out_w;
  logic       zero, carry;

  int checks = 0;
  int failures = 0;

  bus_register_file #(.WIDTH(8), .DEPTH(4), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .enable_in(enable_in), .enable_out(enable_out),
    .op(op), .wr_addr(wr_addr), .rd_addr(rd_addr), .data(data),
    .out(out_w), .zero(zero), .carry(carry)
  );

  always #5 clk = ~clk;

  // Reference model: integer registers, arithmetic straight from the op definitions.
  int m_r [4] = '{0, 0, 0, 0};
  int m_zero = 0, m_carry = 0;
  int m_oe = 0, m_outq = 0;

  typedef struct {
    string      name;
    logic [7:0] out;
    logic       zero;
    logic       carry;
    bit         chk;
  } exp_t;
  exp_t exp_q[$];

  task automatic model_edge();
    int v;
    if (!reset) begin
      foreach (m_r[i]) m_r[i] = 0;
      m_zero = 0; m_carry = 0; m_oe = 0; m_outq = 0;
    end else begin
      if (enable_in && wr_addr < 4 && op != HOLD && op != RSV) begin
        v = m_r[wr_addr];
        case (op)
          LOAD: begin m_carry = 0; v = int'(data); end
          INC:  begin m_carry = (v == 255) ? 1 : 0; v = (v + 1) % 256; end
          DEC:  begin m_carry = (v == 0) ? 1 : 0; v = (v + 255) % 256; end
          SHL:  begin m_carry = v / 128; v = (v * 2) % 256; end
          SHR:  begin m_carry = v % 2; v = v / 2; end
          default: begin m_carry = 0; v = 0; end
        endcase
        m_r[wr_addr] = v;
        m_zero = (v == 0) ? 1 : 0;
      end
      m_oe   = enable_out ? 1 : 0;
      m_outq = (rd_addr < 4) ? m_r[rd_addr] : 0;
    end
  endtask

  task automatic step(input string nm, input logic rst, input logic ein, input logic [2:0] o,
                      input logic [2:0] wa, input logic eo, input logic [2:0] ra,
                      input logic [7:0] d, input bit chk);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    reset = rst; enable_in = ein; op = o; wr_addr = wa;
    enable_out = eo; rd_addr = ra; data = d;
    e.name  = nm;
    e.chk   = chk;
    e.zero  = m_zero[0];
    e.carry = m_carry[0];
`ifdef OUT_REG_EN
    e.out = (m_oe != 0) ? 8'(m_outq) : 8'hzz;
`else
    e.out = eo ? ((ra < 4) ? 8'(m_r[ra]) : 8'h00) : 8'hzz;
`endif
    exp_q.push_back(e);
  endtask

  // Monitor: sample mid-cycle, pop one expectation per cycle and compare.
  exp_t me;
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        me = exp_q.pop_front();
        if (me.chk) begin
          checks++;
          if (out_w !== me.out) begin
            failures++;
            $display("FAIL %s out: got %h expected %h", me.name, out_w, me.out);
          end
          checks++;
          if (zero !== me.zero) begin
            failures++;
            $display("FAIL %s zero: got %b expected %b", me.name, zero, me.zero);
          end
          checks++;
          if (carry !== me.carry) begin
            failures++;
            $display("FAIL %s carry: got %b expected %b", me.name, carry, me.carry);
          end
        end
      end
    end
  end

  task automatic rand_steps(input int n);
    for (int i = 0; i < n; i++)
      step("rand", ($urandom_range(0, 31) != 0), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 5)), 8'($urandom), 1'b1);
  endtask

  initial begin
    step("init", 0, 0, HOLD, 0, 0, 0, 8'h00, 0);
    step("init", 0, 0, HOLD, 0, 0, 0, 8'h00, 0);
    rand_steps(40);

    // Reset after random activity, with a competing LOAD.
    step("rst_ld", 0, 1, LOAD, 0, 1, 0, 8'h77, 1);
    for (int a = 0; a < 4; a++) step("rst_rd", 1, 0, HOLD, 0, 1, 3'(a), 8'h00, 1);
    step("rst_z", 1, 0, HOLD, 0, 0, 0, 8'h00, 1);
    step("rst_z2", 1, 0, HOLD, 0, 0, 0, 8'h00, 1);

    // Load / readback.
    step("ld1", 1, 1, LOAD, 1, 0, 0, 8'hA5, 1);
    step("ld2", 1, 1, LOAD, 2, 0, 0, 8'h3C, 1);
    step("rd1", 1, 0, HOLD, 0, 1, 1, 8'h00, 1);
    step("rd2", 1, 0, HOLD, 0, 1, 2, 8'h00, 1);
    step("rd0", 1, 0, HOLD, 0, 1, 0, 8'h00, 1);
    step("rd3", 1, 0, HOLD, 0, 1, 3, 8'h00, 1);

    // Wrap-around on R0.
    step("ldff", 1, 1, LOAD, 0, 1, 0, 8'hFF, 1);
    step("inc_wrap", 1, 1, INC, 0, 1, 0, 8'h00, 1);
    step("dec_wrap", 1, 1, DEC, 0, 1, 0, 8'h00, 1);
    step("dec", 1, 1, DEC, 0, 1, 0, 8'h00, 1);
    step("wrap_rd", 1, 0, HOLD, 0, 1, 0, 8'h00, 1);

    // Shifts on R3.
    step("ld81", 1, 1, LOAD, 3, 1, 3, 8'h81, 1);
    step("shl", 1, 1, SHL, 3, 1, 3, 8'h00, 1);
    step("shr", 1, 1, SHR, 3, 1, 3, 8'h00, 1);
    step("shr2", 1, 1, SHR, 3, 1, 3, 8'h00, 1);
    step("sh_rd", 1, 0, HOLD, 0, 1, 3, 8'h00, 1);
    step("rsv", 1, 1, RSV, 3, 1, 3, 8'h00, 1);
    step("clr", 1, 1, CLR, 2, 1, 2, 8'h00, 1);
    step("clr_rd", 1, 1, LOAD, 2, 1, 2, 8'h3C, 1);

    // Read during write on R2.
    step("rdw_pre", 1, 1, INC, 2, 1, 2, 8'h00, 1);
    step("rdw_post", 1, 0, HOLD, 0, 1, 2, 8'h00, 1);

    // Reset colliding with LOAD.
    step("rst_col", 0, 1, LOAD, 1, 1, 1, 8'h55, 1);
    step("rst_col_rd", 1, 0, HOLD, 0, 1, 1, 8'h00, 1);

    // Output enable timing on R1.
    step("ldA5", 1, 1, LOAD, 1, 0, 1, 8'hA5, 1);
    step("oe_up", 1, 0, HOLD, 0, 1, 1, 8'h00, 1);
    step("oe_up2", 1, 0, HOLD, 0, 1, 1, 8'h00, 1);
    step("oe_dn", 1, 0, HOLD, 0, 0, 1, 8'h00, 1);
    step("oe_dn2", 1, 0, HOLD, 0, 0, 1, 8'h00, 1);

    // Out-of-range write and read.
    step("oor_wr", 1, 1, LOAD, 5, 1, 5, 8'hEE, 1);
    step("oor_inc", 1, 1, INC, 4, 1, 4, 8'h00, 1);
    step("oor_rd", 1, 0, HOLD, 0, 1, 1, 8'h00, 1);

    rand_steps(400);
    step("flush", 1, 0, HOLD, 0, 0, 0, 8'h00, 1);

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_register_file.md
Name: bus_register_file

Overview:
- Parametrised successor to the single-byte bus register.
- Holds DEPTH general-purpose registers of WIDTH bits, each loadable from the shared data bus.
- Supports in-place arithmetic and shift operations on the selected register.
- Drives the selected register onto the tri-state bus under enable_out, and keeps zero/carry flags for the control unit.

Parameters:
WIDTH, 8, register and bus width in bits (>=2)
DEPTH, 4, number of registers (1..2**ADDR_W)
ADDR_W, 2, width of wr_addr/rd_addr

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-low reset
enable_in  input  1  execute op on register wr_addr this cycle
enable_out  input  1  drive register rd_addr onto out; else out = high-Z
op  input  3  operation code, sampled only when enable_in=1
wr_addr  input  ADDR_W  target register for op
rd_addr  input  ADDR_W  register driven onto out
data  input  WIDTH  bus value used by LOAD
out  output  WIDTH  tri-state bus output
zero  output  1  result of last executed op == 0
carry  output  1  carry/borrow/shifted-out bit of last executed op

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- reset=0 at a rising edge:
  - All registers, zero and carry are set to 0.
  - reset wins over any simultaneous enable_in/op.
  - A half-issued op is discarded.
- op encoding, applied at the edge when enable_in=1 and reset=1, result written to R[wr_addr]:
  - 0 HOLD: no change; flags unchanged.
  - 1 LOAD: R=data; carry=0.
  - 2 INC: R=R+1 mod 2**WIDTH; carry=1 only on all-ones->0 wrap.
  - 3 DEC: R=R-1 mod 2**WIDTH; carry=1 (borrow) only on 0->all-ones wrap.
  - 4 SHL: R={R[WIDTH-2:0],0}; carry=old MSB.
  - 5 SHR: R={0,R[WIDTH-1:1]}; carry=old LSB.
  - 6 CLR: R=0; carry=0.
  - 7 reserved: treated as HOLD.
- zero: updated by every executed op other than HOLD/reserved; equals (new R == 0).
- Flags hold their value when enable_in=0.
- Write latency: result is visible in R on the edge that executes the op; one op per register per cycle.
- Output, without OUT_REG_EN:
  - out = R[rd_addr] combinationally when enable_out=1, else all bits Z.
  - out reflects register contents after the most recent edge.
- Read during write (rd_addr==wr_addr): out shows the pre-edge value until the edge, then the new value. No bypass of data to out.
- Out-of-range address (value >= DEPTH):
  - Writes are ignored; registers and flags are unchanged.
  - Reads drive 0 when enable_out=1.
- After reset, with enable_out=1, out drives 0.
- No registers other than R[wr_addr] change on any edge.

Optional Feature:
OUT_REG_EN:
- Defined: out is driven from an output register loaded each edge with R[rd_addr], as updated by that same edge. The register is cleared by reset.
- Defined: the bus drive enable is enable_out delayed one cycle, also cleared by reset. Read latency is 1 cycle from rd_addr/enable_out to out.
- Undefined: combinational read path as described above, with 0-cycle latency.

Test Plan:
(WIDTH=8, DEPTH=4, macro undefined unless noted)
- Reset: reset=0 one edge after random ops; then enable_out=1, rd_addr=0..3 -> out=0x00 each; zero=0, carry=0; enable_out=0 -> out=ZZ.
- Load/readback: LOAD 0xA5 to R1, 0x3C to R2, then read R1, R2 -> out=0xA5, 0x3C; R0, R3 stay 0x00.
- Wrap-around:
  - LOAD 0xFF to R0, INC -> R0=0x00, carry=1, zero=1.
  - DEC -> R0=0xFF, carry=1, zero=0.
  - DEC -> R0=0xFE, carry=0.
- Shifts: LOAD 0x81 to R3; SHL -> 0x02, carry=1; SHR -> 0x01, carry=0; SHR -> 0x00, carry=1, zero=1.
- Simultaneous events:
  - Same-cycle INC on R2 (0x3C) with rd_addr=2 -> out=0x3C before the edge, 0x3D after.
  - LOAD 0x55 with reset=0 in the same cycle -> R=0x00.
- OUT_REG_EN defined:
  - Raise enable_out with rd_addr=1 (R1=0xA5) -> out Z in that cycle, 0xA5 one cycle later.
  - Drop enable_out -> out Z one cycle later.
